// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver (8N1, LSB first, idle high).
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx #(
  parameter int ticks_per_bit = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err
);

  localparam logic [7:0] LastTick = 8'(ticks_per_bit - 1);
  localparam logic [7:0] HalfTick = 8'(ticks_per_bit / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t     state_q, state_d;
  logic       syncA_q, rxS_q;
  logic [7:0] counter_q, counter_d;
  logic [2:0] bitIdx_q, bitIdx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] dataOut_q, dataOut_d;
  logic       rxDone_q, rxDone_d;
  logic       frameErr_q, frameErr_d;
`ifdef UART_RX_PARITY_EN
  logic       parityBad_q, parityBad_d;
  logic       parityErr_q, parityErr_d;
`endif

  // Synchronizer flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncA_q    <= 1'b1;
      rxS_q      <= 1'b1;
      state_q    <= IDLE;
      counter_q  <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      dataOut_q  <= '0;
      rxDone_q   <= 1'b0;
      frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBad_q <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      syncA_q    <= rx_in;
      rxS_q      <= syncA_q;
      state_q    <= state_d;
      counter_q  <= counter_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      dataOut_q  <= dataOut_d;
      rxDone_q   <= rxDone_d;
      frameErr_q <= frameErr_d;
`ifdef UART_RX_PARITY_EN
      parityBad_q <= parityBad_d;
      parityErr_q <= parityErr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    dataOut_d  = dataOut_q;
    rxDone_d   = 1'b0;
    frameErr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityBad_d = parityBad_q;
    parityErr_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        counter_d = '0;
`ifdef UART_RX_PARITY_EN
        parityBad_d = 1'b0;
`endif
        if (!rxS_q) state_d = START;
      end
      // Re-check the line half a bit in, so short glitches are dropped silently.
      START: begin
        if (counter_q == HalfTick) begin
          counter_d = '0;
          bitIdx_d  = '0;
          state_d   = rxS_q ? IDLE : DATA;
        end else begin
          counter_d = counter_q + 8'd1;
        end
      end
      DATA: begin
        if (counter_q == LastTick) begin
          shift_d[bitIdx_q] = rxS_q;
          counter_d = '0;
          if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          counter_d = counter_q + 8'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (counter_q == LastTick) begin
          counter_d   = '0;
          parityBad_d = (rxS_q != ^shift_q);
          state_d     = STOP;
        end else begin
          counter_d = counter_q + 8'd1;
        end
      end
`endif
      // The byte is published even on a bad stop bit; the strobe says which.
      STOP: begin
        if (counter_q == LastTick) begin
          counter_d = '0;
          dataOut_d = shift_q;
`ifdef UART_RX_PARITY_EN
          parityErr_d = parityBad_q;
`endif
          if (rxS_q) begin
            rxDone_d = 1'b1;
            state_d  = IDLE;
          end else begin
            frameErr_d = 1'b1;
            state_d    = WAIT_HIGH;
          end
        end else begin
          counter_d = counter_q + 8'd1;
        end
      end
      WAIT_HIGH: begin
        counter_d = '0;
        if (rxS_q) state_d = IDLE;
      end
      default: begin
        counter_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  assign data_out  = dataOut_q;
  assign rx_done   = rxDone_q;
  assign frame_err = frameErr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parityErr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
